// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO pair: one shift-add or
// restoring shift-subtract step per cycle, then a sign-fix cycle that writes HI/LO.
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    logic                 a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       trial_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s, rem_s, a_orig_s;
    logic                 sign_x_s;

    // Operand magnitudes, one iteration step and the final sign correction
    always_comb begin
        a_neg_s    = op[0] & a[WIDTH-1];
        b_neg_s    = op[0] & b[WIDTH-1];
        a_mag_s    = a_neg_s ? neg_w(a) : a;
        b_mag_s    = b_neg_s ? neg_w(b) : b;
        // acc = {partial product, remaining multiplier bits}
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
        // acc = {partial remainder, dividend bits shifting into quotient bits}
        trial_s    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
        div_next_s = trial_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        sign_x_s   = op_q[0] & (neg_a_q ^ neg_b_q);
        prod_s     = sign_x_s ? neg_2w(acc_q) : acc_q;
        quo_s      = sign_x_s ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_s      = (op_q[0] & neg_a_q) ? neg_w(acc_q[2*WIDTH-1:WIDTH])
                                         : acc_q[2*WIDTH-1:WIDTH];
        a_orig_s   = neg_a_q ? neg_w(opa_q) : opa_q;
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = CNT_MAX;
                    op_d    = op;
                    neg_a_d = a_neg_s;
                    neg_b_d = b_neg_s;
                    opa_d   = a_mag_s;
                    opb_d   = b_mag_s;
                    acc_d   = {ZERO_W, (op[1] ? a_mag_s : b_mag_s)};
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
                end else begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
                end
            end
            S_CALC: begin
                acc_d = op_q[1] ? div_next_s : mul_next_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (opb_q == ZERO_W) begin
                        hi_d = a_orig_s;
                        lo_d = ONES_W;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 2'b00;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opa_q   <= ZERO_W;
            opb_q   <= ZERO_W;
            acc_q   <= {(2*WIDTH){1'b0}};
            hi_q    <= ZERO_W;
            lo_q    <= ZERO_W;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: vector table, hand-written corner
// sequences and random operations against an arithmetic reference model.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int total = 0;
    int bad = 0;

    mdu_iterative #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint sx, sy, p, q, r;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ez = 1'b0;
        eh = 32'd0;
        el = 32'd0;
        if (o == 2'b00) begin
            up = {32'd0, x} * {32'd0, y};
            eh = up[63:32];
            el = up[31:0];
        end else if (o == 2'b01) begin
            p = sx * sy;
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 32'd0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else if (o == 2'b10) begin
            el = x / y;
            eh = x % y;
        end else begin
            q = sx / sy;
            r = sx % sy;
            el = q[31:0];
            eh = r[31:0];
        end
    endfunction

    // Waits (bounded) for done; lat counts edges after the accept edge
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised done
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        check("accept_busy", {63'd0, busy}, 64'd1);
        check("accept_dz_clear", {63'd0, div_zero}, 64'd0);
        check("accept_done_low", {63'd0, done}, 64'd0);
        wait_done(lat, bcnt);
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [31:0] eh, el, old_hi, old_lo;
        logic ez;

        tbl[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1] = '{2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        tbl[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        tbl[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        tbl[5] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        tbl[6] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        tbl[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
        tbl[8] = '{2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        tbl[9] = '{2'b00, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0};

        #1;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: ops run back to back, each start in the cycle done is high
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcnt);
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'd33);
            check($sformatf("tbl%0d_busy", i), 64'(bcnt), 64'd33);
            check($sformatf("tbl%0d_hi", i), {32'd0, hi}, {32'd0, tbl[i].hi});
            check($sformatf("tbl%0d_lo", i), {32'd0, lo}, {32'd0, tbl[i].lo});
            check($sformatf("tbl%0d_dz", i), {63'd0, div_zero}, {63'd0, tbl[i].dz});
        end
        @(posedge clk); #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // mthi / mtlo in idle, separately then together
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi", {32'd0, hi}, 64'h1234);
        lo_we = 1'b1; wdata = 32'h0000_ABCD;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo", {32'd0, lo}, 64'hABCD);
        check("mtlo_hi_kept", {32'd0, hi}, 64'h1234);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1111;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both", {hi, lo}, {32'h1111, 32'h1111});

        // start and hi_we together: start wins, write dropped
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'h5555;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        check("start_prio_hi", {32'd0, hi}, 64'h1111);
        wait_done(lat, bcnt);
        check("start_prio_res", {hi, lo}, {32'd0, 32'd6});

        // divu 100/7 with start, mthi and mtlo pulses while busy (incl. fix cycle)
        old_hi = hi; old_lo = lo;
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            start = (i == 2 || i == 33);
            hi_we = (i == 10);
            lo_we = (i == 33);
            op = 2'b01; a = 32'hDEAD_0000 + 32'(i); b = 32'd3; wdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            if (done) ndone++;
            if (i == 20) check("calc_hold", {hi, lo}, {old_hi, old_lo});
            if (i == 33) check("busy_div_res", {hi, lo}, {32'd2, 32'd14});
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("busy_one_done", 64'(ndone), 64'd1);
        check("busy_div_final", {hi, lo}, {32'd2, 32'd14});

        // reset in the middle of multu 7*9
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_flags", {61'd0, busy, done, div_zero}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        do_op(2'b00, 32'd7, 32'd9, lat, bcnt);
        check("after_rst_res", {hi, lo}, {32'd0, 32'd63});

        // random ops against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [1:0] ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op(ro, ra, rb, lat, bcnt);
            model(ro, ra, rb, eh, el, ez);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), {hi, lo}, {eh, el});
            check($sformatf("rnd%0d_dz", i), {62'd0, div_zero, 1'(lat == 33)}, {62'd0, ez, 1'b1});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- Executes mult, multu, div and divu iteratively, one bit per cycle, and handles mthi/mtlo writes.
- Sits beside the ALU in the execute stage. The control unit raises start and stalls the PC while busy=1; mfhi/mflo read hi/lo directly.

Parameters:
- WIDTH, 32: operand width and width of each of hi and lo.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  WIDTH  data for mthi/mtlo.
- hi  out  WIDTH  HI register (upper product or remainder).
- lo  out  WIDTH  LO register (lower product or quotient).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when hi/lo are updated by an operation.
- div_zero  out  1  set with done when a div/divu had b==0; held until the next accepted start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). During reset: state=IDLE; hi, lo, busy, done, div_zero, counter and working registers all 0.
- States:
  - IDLE --start--> CALC.
  - CALC stays for WIDTH cycles, then goes to FIX.
  - FIX --> IDLE, unconditionally.
- Accept, at edge E0 in IDLE with start=1:
  - Latch op, sign flags and |a|, |b|. For unsigned ops the magnitude is the raw value.
  - counter=WIDTH, busy=1, div_zero=0.
- CALC, one iteration per edge E1..E_WIDTH, counter decrements:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing one quotient bit per cycle.
- FIX, at edge E_WIDTH+1:
  - Apply sign correction.
  - Write hi/lo; done=1 and busy=0 for exactly that one cycle. Return to IDLE.
  - Total latency: done is visible WIDTH+1 cycles after the start edge.
  - done is deasserted at the following edge.
- Signed rules:
  - mult: product negated if sign(a)^sign(b).
  - div: quotient truncates toward zero; remainder takes the sign of the dividend.
- Overflow: div with a=most-negative and b=-1 gives lo=most-negative, hi=0 (two's-complement wrap); no flag.
- Divide by zero (b==0 with op 1x):
  - Same latency as a normal operation.
  - At FIX: hi=a (original, unsigned view), lo=all ones, div_zero=1.
- Back-to-back: a start in the cycle immediately after done is accepted normally.
- mthi/mtlo:
  - In IDLE without start: hi_we loads hi and lo_we loads lo at the next edge; both may be set together.
  - Ignored while busy=1.
  - Ignored in the cycle start is accepted (start has priority).
- start while busy=1 is ignored; the in-flight operation is unaffected.
- a, b and op are only sampled at accept; later changes have no effect.
- hi/lo hold their old values throughout CALC and change only at FIX or on mthi/mtlo.
- Reset asserted mid-operation: immediate abort and all-zero state; no done pulse.

Test Plan (WIDTH=32):
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after the start edge; busy high for 33 cycles.
- mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100, b=0 -> hi=100, lo=0xFFFFFFFF, div_zero=1 with done. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- divu a=100, b=7, with start re-pulsed and hi_we/lo_we pulsed mid-operation -> ignored; result lo=14, hi=2; exactly one done pulse.
- In IDLE: hi_we=1 with wdata=0x1234, then lo_we=1 with wdata=0xABCD -> hi=0x1234, lo=0xABCD after one edge each. start with hi_we in the same cycle -> operation runs and the write is dropped.
- Start multu 7*9, then assert rst_n=0 at cycle 10 -> hi=lo=0 and busy=0 immediately, no done pulse. After release, multu 7*9 -> lo=63, hi=0.
